packet_header_extractor: RTL

PACKET_HEADER_EXTRACTOR -- requirements
Module: packet_header_extractor

---
 rtl/packet_header_extractor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/packet_header_extractor.sv
// Splits an AXI-Stream packet flow: every beat is forwarded through one register stage,
// and each packet's first beat is also copied into a small FWFT header FIFO.
// Optional byte-length check against tuser[15:0] of the first beat: define PKT_LEN_CHECK_EN.
module packet_header_extractor #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int HDR_FIFO_DEPTH_BITS  = 2
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_pkt_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_pkt_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_pkt_tuser,
    output logic                              m_axis_pkt_tvalid,
    output logic                              m_axis_pkt_tlast,
    input  logic                              m_axis_pkt_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_hdr_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_hdr_tuser,
    output logic                              m_axis_hdr_tvalid,
    input  logic                              m_axis_hdr_tready,

    output logic [31:0]                       pkt_count,
    output logic [15:0]                       len_err_count,
    output logic                              len_err
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int HDR_W  = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH;
    localparam int DEPTH  = 1 << HDR_FIFO_DEPTH_BITS;
    localparam int PTR_W  = HDR_FIFO_DEPTH_BITS + 1;

    typedef enum logic {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    state_e                            state_q, state_d;

    logic                              pkt_tvalid_q, pkt_tvalid_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    pkt_tdata_q, pkt_tdata_d;
    logic [KEEP_W-1:0]                 pkt_tkeep_q, pkt_tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   pkt_tuser_q, pkt_tuser_d;
    logic                              pkt_tlast_q, pkt_tlast_d;

    logic [PTR_W-1:0]                  hdr_wr_ptr_q, hdr_wr_ptr_d;
    logic [PTR_W-1:0]                  hdr_rd_ptr_q, hdr_rd_ptr_d;
    logic [HDR_W-1:0]                  hdr_mem_q [DEPTH];
    logic                              hdr_full, hdr_empty, hdr_push, hdr_pop;

    logic [31:0]                       pkt_count_q, pkt_count_d;
    logic                              beat_accept;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign hdr_empty = (hdr_wr_ptr_q == hdr_rd_ptr_q);
    assign hdr_full  = ((hdr_wr_ptr_q - hdr_rd_ptr_q) == PTR_W'(DEPTH));

    // Only a first beat needs a header slot, so body beats never wait on the FIFO.
    assign s_axis_tready = axi_resetn
                         & (~pkt_tvalid_q | m_axis_pkt_tready)
                         & ~((state_q == ST_SOP) & hdr_full);
    assign beat_accept   = s_axis_tvalid & s_axis_tready;
    assign hdr_push      = beat_accept & (state_q == ST_SOP);
    assign hdr_pop       = ~hdr_empty & m_axis_hdr_tready;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pkt_tvalid_d = pkt_tvalid_q;
        pkt_tdata_d  = pkt_tdata_q;
        pkt_tkeep_d  = pkt_tkeep_q;
        pkt_tuser_d  = pkt_tuser_q;
        pkt_tlast_d  = pkt_tlast_q;
        hdr_wr_ptr_d = hdr_wr_ptr_q + PTR_W'(hdr_push);
        hdr_rd_ptr_d = hdr_rd_ptr_q + PTR_W'(hdr_pop);
        pkt_count_d  = pkt_count_q;

        if (beat_accept) begin
            // A tlast beat always returns to SOP; any other beat leaves us inside a packet.
            state_d      = s_axis_tlast ? ST_SOP : ST_BODY;
            pkt_tvalid_d = 1'b1;
            pkt_tdata_d  = s_axis_tdata;
            pkt_tkeep_d  = s_axis_tkeep;
            pkt_tuser_d  = s_axis_tuser;
            pkt_tlast_d  = s_axis_tlast;
            if (s_axis_tlast) begin
                pkt_count_d = pkt_count_q + 32'd1;
            end
        end else if (m_axis_pkt_tready) begin
            pkt_tvalid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= ST_SOP;
            pkt_tvalid_q <= 1'b0;
            hdr_wr_ptr_q <= '0;
            hdr_rd_ptr_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            pkt_tvalid_q <= pkt_tvalid_d;
            hdr_wr_ptr_q <= hdr_wr_ptr_d;
            hdr_rd_ptr_q <= hdr_rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    // NOTE: payload registers and header storage are not reset; their valid flags gate them.
    always_ff @(posedge axi_aclk) begin
        pkt_tdata_q <= pkt_tdata_d;
        pkt_tkeep_q <= pkt_tkeep_d;
        pkt_tuser_q <= pkt_tuser_d;
        pkt_tlast_q <= pkt_tlast_d;
    end

    always_ff @(posedge axi_aclk) begin
        if (hdr_push) begin
            hdr_mem_q[hdr_wr_ptr_q[HDR_FIFO_DEPTH_BITS-1:0]] <= {s_axis_tuser, s_axis_tdata};
        end
    end

    assign m_axis_pkt_tvalid = pkt_tvalid_q;
    assign m_axis_pkt_tdata  = pkt_tdata_q;
    assign m_axis_pkt_tkeep  = pkt_tkeep_q;
    assign m_axis_pkt_tuser  = pkt_tuser_q;
    assign m_axis_pkt_tlast  = pkt_tlast_q;

    assign m_axis_hdr_tvalid = ~hdr_empty;
    assign {m_axis_hdr_tuser, m_axis_hdr_tdata} = hdr_mem_q[hdr_rd_ptr_q[HDR_FIFO_DEPTH_BITS-1:0]];

    assign pkt_count = pkt_count_q;

`ifdef PKT_LEN_CHECK_EN
    logic [31:0] byte_sum_q, byte_sum_d;
    logic [15:0] exp_len_q, exp_len_d;
    logic [15:0] len_err_count_q, len_err_count_d;
    logic        len_err_q, len_err_d;
    logic [15:0] beat_bytes;
    logic [31:0] sum_now;
    logic [15:0] exp_now;

    function automatic logic [15:0] keep_popcount(input logic [KEEP_W-1:0] keep);
        logic [15:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + 16'(keep[i]);
        end
        return cnt;
    endfunction

    assign beat_bytes = keep_popcount(s_axis_tkeep);
    // A first beat restarts the sum and latches the expected length it carries.
    assign sum_now    = ((state_q == ST_SOP) ? 32'd0 : byte_sum_q) + 32'(beat_bytes);
    assign exp_now    = (state_q == ST_SOP) ? s_axis_tuser[15:0] : exp_len_q;

    always_comb begin
        byte_sum_d      = byte_sum_q;
        exp_len_d       = exp_len_q;
        len_err_count_d = len_err_count_q;
        len_err_d       = 1'b0;
        if (beat_accept) begin
            byte_sum_d = sum_now;
            exp_len_d  = exp_now;
            if (s_axis_tlast && (sum_now != {16'd0, exp_now})) begin
                len_err_d = 1'b1;
                if (len_err_count_q != 16'hFFFF) begin
                    len_err_count_d = len_err_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            byte_sum_q      <= '0;
            exp_len_q       <= '0;
            len_err_count_q <= '0;
            len_err_q       <= 1'b0;
        end else begin
            byte_sum_q      <= byte_sum_d;
            exp_len_q       <= exp_len_d;
            len_err_count_q <= len_err_count_d;
            len_err_q       <= len_err_d;
        end
    end

    assign len_err       = len_err_q;
    assign len_err_count = len_err_count_q;
`else
    assign len_err       = 1'b0;
    assign len_err_count = 16'd0;
`endif

endmodule
